tag_release_sched: RTL and testbench

Release-side scheduler for the physical-register tag freelist. It merges two release sources onto the freelist's two release ports: in-order commit releases from retirement, and squash releases from branch-misprediction recovery. Commit releases are buffered in a small FIFO and drained two per cycle. On `prmiss` a two-state FSM hands the ports exclusively to the recovery walker until it signals the last tag, and holds front-end rename stalled via `recover_busy`.

---
 rtl/tag_release_sched_pkg.sv | 25 ++
 rtl/tag_release_sched_sync_fifo2w2r.sv | 87 ++++++++
 rtl/tag_release_sched.sv | 182 ++++++++++++++++++
 tb/tb_tag_release_sched.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tag_release_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tag_release_sched_pkg
// Description : Shared constants for the tag release scheduler: default tag
//               width and commit FIFO depth, FSM state encodings, and a small
//               helper that sizes a two-slot release beat.
// Revision    : 1.0 - initial release
// ============================================================================
package tag_release_sched_pkg;

    localparam int TAG_W_DEFAULT  = 6;
    localparam int QDEPTH_DEFAULT = 8;

    // FSM state encoding
    localparam int         ST_W       = 1;
    localparam logic [0:0] ST_NORMAL  = 1'b0;
    localparam logic [0:0] ST_RECOVER = 1'b1;

    // Number of occupied slots in a two-slot beat (0, 1 or 2).
    function automatic logic [1:0] beat_size(input logic v1, input logic v2);
        return {1'b0, v1} + {1'b0, v2};
    endfunction

endpackage : tag_release_sched_pkg
`default_nettype wire

// File: rtl/tag_release_sched_sync_fifo2w2r.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo2w2r
// Description : Two-write / two-read compacting synchronous FIFO.
//               Up to two entries are pushed per cycle; a lone slot-2 write is
//               stored as if it were slot 1 so storage stays dense. The two
//               oldest entries are always presented on rd_data_1_o/rd_data_2_o
//               and the consumer pops 0..2 of them via rd_num_i.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               wr_valid_*_i/wr_data_*_i - push slots (ignored if !wr_ready_o)
//               wr_ready_o         - at least two free entries
//               rd_num_i           - entries popped this cycle (<= count_o)
//               rd_data_*_o        - head and head+1 entries
//               count_o            - current occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo2w2r
    import tag_release_sched_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid_1_i,
    input  logic             wr_valid_2_i,
    input  logic [WIDTH-1:0] wr_data_1_i,
    input  logic [WIDTH-1:0] wr_data_2_i,
    output logic             wr_ready_o,
    input  logic [1:0]       rd_num_i,
    output logic [WIDTH-1:0] rd_data_1_o,
    output logic [WIDTH-1:0] rd_data_2_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             push_en;
    logic [1:0]       push_num;
    logic [WIDTH-1:0] first_data;

    // Ready is derived from registered occupancy only, so it never depends
    // combinationally on the write valids.
    assign wr_ready_o = ((CNT_W'(DEPTH) - count_q) >= CNT_W'(2));
    assign push_en    = wr_ready_o & (wr_valid_1_i | wr_valid_2_i);
    assign push_num   = push_en ? beat_size(wr_valid_1_i, wr_valid_2_i) : 2'd0;

    // Compaction: slot 1 data if present, otherwise slot 2 moves down.
    assign first_data = wr_valid_1_i ? wr_data_1_i : wr_data_2_i;

    assign wr_ptr_d = wr_ptr_q + PTR_W'(push_num);
    assign rd_ptr_d = rd_ptr_q + PTR_W'(rd_num_i);
    assign count_d  = count_q + CNT_W'(push_num) - CNT_W'(rd_num_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= first_data;
            if (wr_valid_1_i && wr_valid_2_i) begin
                mem_q[wr_ptr_q + PTR_W'(1)] <= wr_data_2_i;
            end
        end
    end

    assign rd_data_1_o = mem_q[rd_ptr_q];
    assign rd_data_2_o = mem_q[rd_ptr_q + PTR_W'(1)];
    assign count_o     = count_q;

endmodule : sync_fifo2w2r
`default_nettype wire

// File: rtl/tag_release_sched.sv
`default_nettype none
// ============================================================================
// Module      : tag_release_sched
// Description : Release-side scheduler for the physical-register freelist.
//               Merges in-order commit releases (buffered, drained two per
//               cycle) and misprediction squash releases (direct path) onto
//               two freelist release ports. A NORMAL/RECOVER FSM gives the
//               ports exclusively to the squash walker from prmiss until the
//               sq_last beat is accepted.
// Ports       : clk, reset               - clock, sync active-high reset
//               prmiss                   - misprediction pulse
//               com_valid_*/com_tag_*    - commit release slots
//               com_ready                - commit FIFO has room for two
//               sq_valid_*/sq_tag_*      - squash release slots
//               sq_last                  - final squash beat marker
//               sq_ready                 - squash beat accepted (RECOVER)
//               released_*/released_valid_* - freelist release ports
//               recover_busy             - registered RECOVER indication
//               fifo_count               - commit FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module tag_release_sched
    import tag_release_sched_pkg::*;
#(
    parameter int TAG_W  = TAG_W_DEFAULT,
    parameter int QDEPTH = QDEPTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      prmiss,
    input  logic                      com_valid_1,
    input  logic                      com_valid_2,
    input  logic [TAG_W-1:0]          com_tag_1,
    input  logic [TAG_W-1:0]          com_tag_2,
    output logic                      com_ready,
    input  logic                      sq_valid_1,
    input  logic                      sq_valid_2,
    input  logic [TAG_W-1:0]          sq_tag_1,
    input  logic [TAG_W-1:0]          sq_tag_2,
    input  logic                      sq_last,
    output logic                      sq_ready,
    output logic [TAG_W-1:0]          released_1,
    output logic [TAG_W-1:0]          released_2,
    output logic                      released_valid_1,
    output logic                      released_valid_2,
    output logic                      recover_busy,
    output logic [$clog2(QDEPTH):0]   fifo_count
);

    localparam int CNT_W = $clog2(QDEPTH) + 1;

    logic [ST_W-1:0]  state_q, state_d;

    logic [TAG_W-1:0] rel_1_q, rel_1_d;
    logic [TAG_W-1:0] rel_2_q, rel_2_d;
    logic             rel_valid_1_q, rel_valid_1_d;
    logic             rel_valid_2_q, rel_valid_2_d;
    logic             busy_q, busy_d;

    logic [1:0]       pop_num;
    logic [TAG_W-1:0] fifo_rd_1, fifo_rd_2;
    logic [CNT_W-1:0] fifo_cnt;

    // ------------------------------------------------------------------
    // Commit FIFO
    // ------------------------------------------------------------------
    sync_fifo2w2r #(
        .WIDTH (TAG_W),
        .DEPTH (QDEPTH)
    ) u_commit_fifo (
        .clk          (clk),
        .reset        (reset),
        .wr_valid_1_i (com_valid_1),
        .wr_valid_2_i (com_valid_2),
        .wr_data_1_i  (com_tag_1),
        .wr_data_2_i  (com_tag_2),
        .wr_ready_o   (com_ready),
        .rd_num_i     (pop_num),
        .rd_data_1_o  (fifo_rd_1),
        .rd_data_2_o  (fifo_rd_2),
        .count_o      (fifo_cnt)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. Every RECOVER cycle accepts a squash beat, so an
    // sq_last seen in RECOVER always ends recovery, even with no valids
    // (zero-tag end marker). prmiss in RECOVER has no effect.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_NORMAL:  if (prmiss)  state_d = ST_RECOVER;
            ST_RECOVER: if (sq_last) state_d = ST_NORMAL;
            default:    state_d = ST_NORMAL;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and port mux
    // ------------------------------------------------------------------
    always_comb begin
        sq_ready      = 1'b0;
        pop_num       = 2'd0;
        rel_1_d       = '0;
        rel_2_d       = '0;
        rel_valid_1_d = 1'b0;
        rel_valid_2_d = 1'b0;
        busy_d        = (state_d == ST_RECOVER);

        case (state_q)
            ST_NORMAL: begin
                // The prmiss cycle pops nothing so no commit tag is lost
                // to an output slot that recovery then overwrites.
                if (!prmiss) begin
                    pop_num = (fifo_cnt >= CNT_W'(2)) ? 2'd2 : fifo_cnt[1:0];
                end
                if (pop_num != 2'd0) begin
                    rel_valid_1_d = 1'b1;
                    rel_1_d       = fifo_rd_1;
                end
                if (pop_num == 2'd2) begin
                    rel_valid_2_d = 1'b1;
                    rel_2_d       = fifo_rd_2;
                end
            end
            ST_RECOVER: begin
                sq_ready = 1'b1;
                if (sq_valid_1) begin
                    rel_valid_1_d = 1'b1;
                    rel_1_d       = sq_tag_1;
                end else if (sq_valid_2) begin
                    rel_valid_1_d = 1'b1;
                    rel_1_d       = sq_tag_2;
                end
                if (sq_valid_1 && sq_valid_2) begin
                    rel_valid_2_d = 1'b1;
                    rel_2_d       = sq_tag_2;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rel_1_q       <= '0;
            rel_2_q       <= '0;
            rel_valid_1_q <= 1'b0;
            rel_valid_2_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            rel_1_q       <= rel_1_d;
            rel_2_q       <= rel_2_d;
            rel_valid_1_q <= rel_valid_1_d;
            rel_valid_2_q <= rel_valid_2_d;
            busy_q        <= busy_d;
        end
    end

    assign released_1       = rel_1_q;
    assign released_2       = rel_2_q;
    assign released_valid_1 = rel_valid_1_q;
    assign released_valid_2 = rel_valid_2_q;
    assign recover_busy     = busy_q;
    assign fifo_count       = fifo_cnt;

endmodule : tag_release_sched
`default_nettype wire

// File: tb/tb_tag_release_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_tag_release_sched
// Description : Directed self-checking bench for tag_release_sched.
//               Inputs change 1 time unit after the rising edge; outputs are
//               sampled at the same point, i.e. they reflect the last edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tag_release_sched;

    localparam int TAG_W  = 6;
    localparam int QDEPTH = 8;

    logic             clk;
    logic             reset;
    logic             prmiss;
    logic             com_valid_1, com_valid_2;
    logic [TAG_W-1:0] com_tag_1, com_tag_2;
    logic             com_ready;
    logic             sq_valid_1, sq_valid_2;
    logic [TAG_W-1:0] sq_tag_1, sq_tag_2;
    logic             sq_last;
    logic             sq_ready;
    logic [TAG_W-1:0] released_1, released_2;
    logic             released_valid_1, released_valid_2;
    logic             recover_busy;
    logic [3:0]       fifo_count;

    int errors = 0;
    int checks = 0;

    tag_release_sched #(
        .TAG_W  (TAG_W),
        .QDEPTH (QDEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .prmiss           (prmiss),
        .com_valid_1      (com_valid_1),
        .com_valid_2      (com_valid_2),
        .com_tag_1        (com_tag_1),
        .com_tag_2        (com_tag_2),
        .com_ready        (com_ready),
        .sq_valid_1       (sq_valid_1),
        .sq_valid_2       (sq_valid_2),
        .sq_tag_1         (sq_tag_1),
        .sq_tag_2         (sq_tag_2),
        .sq_last          (sq_last),
        .sq_ready         (sq_ready),
        .released_1       (released_1),
        .released_2       (released_2),
        .released_valid_1 (released_valid_1),
        .released_valid_2 (released_valid_2),
        .recover_busy     (recover_busy),
        .fifo_count       (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic v1, input int t1, input logic v2, input int t2);
        com_valid_1 = v1;
        com_tag_1   = TAG_W'(t1);
        com_valid_2 = v2;
        com_tag_2   = TAG_W'(t2);
    endtask

    task automatic squash(input logic v1, input int t1, input logic v2, input int t2, input logic last);
        sq_valid_1 = v1;
        sq_tag_1   = TAG_W'(t1);
        sq_valid_2 = v2;
        sq_tag_2   = TAG_W'(t2);
        sq_last    = last;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (released_1 !== 6'd0) begin errors++; $display("FAIL reset_rel1: got %0d exp 0", released_1); end
        checks++; if (released_2 !== 6'd0) begin errors++; $display("FAIL reset_rel2: got %0d exp 0", released_2); end
        checks++; if (released_valid_1 !== 1'b0 || released_valid_2 !== 1'b0) begin errors++; $display("FAIL reset_valids: got %b%b exp 00", released_valid_1, released_valid_2); end
        checks++; if (recover_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", recover_busy); end
        checks++; if (sq_ready !== 1'b0) begin errors++; $display("FAIL reset_sq_ready: got %b exp 0", sq_ready); end
        checks++; if (com_ready !== 1'b1) begin errors++; $display("FAIL reset_com_ready: got %b exp 1", com_ready); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", fifo_count); end
        reset = 1'b0;
    endtask

    task automatic test_push_pair();
        push(1'b1, 5, 1'b1, 9);
        tick();
        push(1'b0, 0, 1'b0, 0);
        checks++; if (fifo_count !== 4'd2) begin errors++; $display("FAIL pair_count_after_push: got %0d exp 2", fifo_count); end
        checks++; if (released_valid_1 !== 1'b0) begin errors++; $display("FAIL pair_early_valid: got %b exp 0", released_valid_1); end
        tick();
        checks++; if (released_1 !== 6'd5 || released_2 !== 6'd9) begin errors++; $display("FAIL pair_tags: got %0d,%0d exp 5,9", released_1, released_2); end
        checks++; if (released_valid_1 !== 1'b1 || released_valid_2 !== 1'b1) begin errors++; $display("FAIL pair_valids: got %b%b exp 11", released_valid_1, released_valid_2); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL pair_count_drained: got %0d exp 0", fifo_count); end
        tick();
        checks++; if (released_valid_1 !== 1'b0 || released_valid_2 !== 1'b0) begin errors++; $display("FAIL pair_one_cycle: got %b%b exp 00", released_valid_1, released_valid_2); end
    endtask

    task automatic test_lone_slot2();
        push(1'b0, 0, 1'b1, 12);
        tick();
        push(1'b0, 0, 1'b0, 0);
        checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL lone_count: got %0d exp 1", fifo_count); end
        tick();
        checks++; if (released_1 !== 6'd12) begin errors++; $display("FAIL lone_tag: got %0d exp 12", released_1); end
        checks++; if (released_valid_1 !== 1'b1 || released_valid_2 !== 1'b0) begin errors++; $display("FAIL lone_valids: got %b%b exp 10", released_valid_1, released_valid_2); end
        tick();
    endtask

    task automatic test_prmiss_squash();
        push(1'b1, 20, 1'b1, 21);
        tick();
        push(1'b1, 22, 1'b0, 0);
        prmiss = 1'b1;
        tick();
        push(1'b0, 0, 1'b0, 0);
        prmiss = 1'b0;
        checks++; if (fifo_count !== 4'd3) begin errors++; $display("FAIL miss_count: got %0d exp 3", fifo_count); end
        checks++; if (recover_busy !== 1'b1 || sq_ready !== 1'b1) begin errors++; $display("FAIL miss_busy_ready: got %b%b exp 11", recover_busy, sq_ready); end
        checks++; if (released_valid_1 !== 1'b0) begin errors++; $display("FAIL miss_no_pop: got %b exp 0", released_valid_1); end
        squash(1'b1, 40, 1'b1, 41, 1'b0);
        tick();
        checks++; if (released_1 !== 6'd40 || released_2 !== 6'd41 || released_valid_2 !== 1'b1) begin errors++; $display("FAIL sq_beat1: got %0d,%0d v2=%b exp 40,41 v2=1", released_1, released_2, released_valid_2); end
        checks++; if (recover_busy !== 1'b1) begin errors++; $display("FAIL sq_busy_mid: got %b exp 1", recover_busy); end
        squash(1'b1, 42, 1'b0, 0, 1'b1);
        tick();
        squash(1'b0, 0, 1'b0, 0, 1'b0);
        checks++; if (released_1 !== 6'd42 || released_valid_1 !== 1'b1 || released_valid_2 !== 1'b0) begin errors++; $display("FAIL sq_beat2: got %0d v=%b%b exp 42 v=10", released_1, released_valid_1, released_valid_2); end
        checks++; if (recover_busy !== 1'b0 || sq_ready !== 1'b0) begin errors++; $display("FAIL sq_end_busy_ready: got %b%b exp 00", recover_busy, sq_ready); end
        checks++; if (fifo_count !== 4'd3) begin errors++; $display("FAIL sq_end_count: got %0d exp 3", fifo_count); end
        tick();
        checks++; if (released_1 !== 6'd20 || released_2 !== 6'd21 || released_valid_2 !== 1'b1) begin errors++; $display("FAIL drain1: got %0d,%0d v2=%b exp 20,21 v2=1", released_1, released_2, released_valid_2); end
        checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL drain1_count: got %0d exp 1", fifo_count); end
        tick();
        checks++; if (released_1 !== 6'd22 || released_valid_1 !== 1'b1 || released_valid_2 !== 1'b0) begin errors++; $display("FAIL drain2: got %0d v=%b%b exp 22 v=10", released_1, released_valid_1, released_valid_2); end
        tick();
        checks++; if (released_valid_1 !== 1'b0 || fifo_count !== 4'd0) begin errors++; $display("FAIL drain_idle: got v1=%b cnt=%0d exp v1=0 cnt=0", released_valid_1, fifo_count); end
    endtask

    task automatic test_fill();
        prmiss = 1'b1;
        push(1'b1, 0, 1'b1, 1);
        tick();
        prmiss = 1'b0;
        checks++; if (recover_busy !== 1'b1 || fifo_count !== 4'd2) begin errors++; $display("FAIL fill_start: got busy=%b cnt=%0d exp busy=1 cnt=2", recover_busy, fifo_count); end
        for (int n = 2; n <= 6; n += 2) begin
            push(1'b1, n, 1'b1, n + 1);
            tick();
        end
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL fill_full_count: got %0d exp 8", fifo_count); end
        checks++; if (com_ready !== 1'b0) begin errors++; $display("FAIL fill_com_ready: got %b exp 0", com_ready); end
        push(1'b1, 8, 1'b1, 9);
        tick();
        push(1'b0, 0, 1'b0, 0);
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL fill_drop: got %0d exp 8", fifo_count); end
        squash(1'b0, 0, 1'b0, 0, 1'b1);
        tick();
        squash(1'b0, 0, 1'b0, 0, 1'b0);
        checks++; if (recover_busy !== 1'b0 || released_valid_1 !== 1'b0) begin errors++; $display("FAIL fill_end_marker: got busy=%b v1=%b exp 0,0", recover_busy, released_valid_1); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (released_1 !== TAG_W'(2 * i) || released_2 !== TAG_W'(2 * i + 1) ||
                released_valid_1 !== 1'b1 || released_valid_2 !== 1'b1 || fifo_count !== 4'(6 - 2 * i)) begin
                errors++;
                $display("FAIL fill_drain%0d: got %0d,%0d v=%b%b cnt=%0d exp %0d,%0d v=11 cnt=%0d",
                         i, released_1, released_2, released_valid_1, released_valid_2, fifo_count,
                         2 * i, 2 * i + 1, 6 - 2 * i);
            end
        end
        tick();
        checks++; if (released_valid_1 !== 1'b0 || fifo_count !== 4'd0 || com_ready !== 1'b1) begin errors++; $display("FAIL fill_empty: got v1=%b cnt=%0d rdy=%b exp 0,0,1", released_valid_1, fifo_count, com_ready); end
    endtask

    task automatic test_double_prmiss();
        prmiss = 1'b1;
        tick();
        checks++; if (recover_busy !== 1'b1) begin errors++; $display("FAIL dbl_enter: got %b exp 1", recover_busy); end
        squash(1'b1, 50, 1'b0, 0, 1'b0);
        tick();
        checks++; if (recover_busy !== 1'b1 || released_1 !== 6'd50 || released_valid_2 !== 1'b0) begin errors++; $display("FAIL dbl_mid: got busy=%b tag=%0d v2=%b exp 1,50,0", recover_busy, released_1, released_valid_2); end
        squash(1'b1, 51, 1'b1, 52, 1'b1);
        tick();
        prmiss = 1'b0;
        squash(1'b0, 0, 1'b0, 0, 1'b0);
        checks++; if (recover_busy !== 1'b0 || released_1 !== 6'd51 || released_2 !== 6'd52) begin errors++; $display("FAIL dbl_last: got busy=%b %0d,%0d exp 0,51,52", recover_busy, released_1, released_2); end
        tick();
        checks++; if (recover_busy !== 1'b0 || released_valid_1 !== 1'b0) begin errors++; $display("FAIL dbl_after: got busy=%b v1=%b exp 0,0", recover_busy, released_valid_1); end
    endtask

    task automatic test_reset_in_recover();
        push(1'b1, 1, 1'b1, 2);
        tick();
        push(1'b1, 3, 1'b1, 4);
        prmiss = 1'b1;
        tick();
        prmiss = 1'b0;
        push(1'b1, 5, 1'b0, 0);
        squash(1'b1, 60, 1'b1, 61, 1'b0);
        tick();
        push(1'b0, 0, 1'b0, 0);
        squash(1'b0, 0, 1'b0, 0, 1'b0);
        checks++; if (fifo_count !== 4'd5 || recover_busy !== 1'b1 || released_1 !== 6'd60) begin errors++; $display("FAIL rir_setup: got cnt=%0d busy=%b tag=%0d exp 5,1,60", fifo_count, recover_busy, released_1); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (recover_busy !== 1'b0 || sq_ready !== 1'b0) begin errors++; $display("FAIL rir_state: got busy=%b sq_ready=%b exp 0,0", recover_busy, sq_ready); end
        checks++; if (fifo_count !== 4'd0 || com_ready !== 1'b1) begin errors++; $display("FAIL rir_fifo: got cnt=%0d rdy=%b exp 0,1", fifo_count, com_ready); end
        checks++; if (released_valid_1 !== 1'b0 || released_valid_2 !== 1'b0) begin errors++; $display("FAIL rir_valids: got %b%b exp 00", released_valid_1, released_valid_2); end
        tick();
        checks++; if (released_valid_1 !== 1'b0 || fifo_count !== 4'd0) begin errors++; $display("FAIL rir_no_stale: got v1=%b cnt=%0d exp 0,0", released_valid_1, fifo_count); end
    endtask

    initial begin
        reset  = 1'b1;
        prmiss = 1'b0;
        push(1'b0, 0, 1'b0, 0);
        squash(1'b0, 0, 1'b0, 0, 1'b0);

        test_reset();
        test_push_pair();
        test_lone_slot2();
        test_prmiss_squash();
        test_fill();
        test_double_prmiss();
        test_reset_in_recover();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_tag_release_sched
`default_nettype wire
